unidade_busca: RTL and testbench

UNIDADE_BUSCA -- requirements
Module: unidade_busca

---
 rtl/unidade_busca.sv | 144 ++++++++++++++
 tb/tb_unidade_busca.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// Instruction fetch unit: one outstanding memory request feeding a small FIFO of
// {instr, pc} entries; a redirect flushes the FIFO and retargets fetching.
module unidade_busca #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [31:0] pc_atual
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic [CW-1:0] count_pop;
    logic [CW-1:0] count_post;
    logic [31:0]   target;
    logic [31:0]   pc_next_seq;
    logic          unused_target_bits;

    // Fetch targets are always word aligned, so the low redirect bits are dropped.
    assign unused_target_bits = ^redirect_pc[1:0];

    always_comb begin
        pop         = (count != '0) && instr_ready;
        push        = (state == S_WAIT) && imem_ack && !redirect;
        count_pop   = count - {{(CW-1){1'b0}}, pop};
        count_post  = count_pop + {{(CW-1){1'b0}}, push};
        target      = {redirect_pc[31:2], 2'b00};
        pc_next_seq = pc_atual + 32'd4;
    end

    assign instr_valid = (count != '0);
    assign instr       = buf_instr[head];
    assign instr_pc    = buf_pc[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'd0;
            pc_atual  <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        pc_atual <= target;
                    end else if (count_pop < DEPTH_C) begin
                        state     <= S_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_atual;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc_atual <= target;
                        if (imem_ack) begin
                            imem_addr <= target;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc_atual <= pc_next_seq;
                        if (count_post < DEPTH_C) begin
                            imem_addr <= pc_next_seq;
                        end else begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                S_DISCARD: begin
                    // The response in flight belongs to a stale path and is never pushed.
                    if (redirect) begin
                        pc_atual <= target;
                        if (imem_ack) begin
                            state     <= S_WAIT;
                            imem_addr <= target;
                        end
                    end else if (imem_ack) begin
                        state     <= S_WAIT;
                        imem_addr <= pc_atual;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                buf_instr[tail] <= imem_rdata;
                buf_pc[tail]    <= imem_addr;
                tail            <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count_post;
        end
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed reset/latency/redirect scenarios plus random
// traffic, with deliveries scored against an address-stream model.
module tb_unidade_busca;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] pc_atual;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          tests;
    int          fails;
    int          deliveries;

    unidade_busca #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .pc_atual(pc_atual)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory contents are a fixed function of the address.
    assign imem_rdata = mem_word(imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_restart(input logic [31:0] start);
        exp_q.delete();
        model_pc = start;
    endtask

    // The delivered stream is simply consecutive words from the last restart point.
    task automatic model_fill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc     = model_pc;
            e.ins    = mem_word(model_pc);
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
        imem_ack    = ack;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = tgt;
        if (redir) model_restart({tgt[31:2], 2'b00});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_fill();
    endtask

    // Monitor: every consumed instruction is popped from the scoreboard and compared.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (imem_req) checkOutput("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL deliv_unexpected: got pc %08h expected nothing", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("deliv_pc", instr_pc, e.pc);
                    checkOutput("deliv_instr", instr, e.ins);
                    deliveries++;
                end
            end
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        deliveries = 0;
        reset      = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        model_restart(RST_PC);
        repeat (3) cyc();
        checkOutput("rst_req", 32'(imem_req), 0);
        checkOutput("rst_addr", imem_addr, 0);
        checkOutput("rst_valid", 32'(instr_valid), 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_instr_pc", instr_pc, 0);
        checkOutput("rst_pc_atual", pc_atual, RST_PC);

        // Release with the ack held low for three cycles after the first request.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        cyc();
        checkOutput("first_req", 32'(imem_req), 1);
        checkOutput("first_addr", imem_addr, RST_PC);
        checkOutput("first_valid", 32'(instr_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checkOutput("held_req", 32'(imem_req), 1);
            checkOutput("held_addr", imem_addr, RST_PC);
            checkOutput("held_novalid", 32'(instr_valid), 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        cyc();
        checkOutput("ack_valid", 32'(instr_valid), 1);
        checkOutput("ack_instr_pc", instr_pc, RST_PC);
        checkOutput("ack_instr", instr, mem_word(RST_PC));
        checkOutput("ack_pc_atual", pc_atual, RST_PC + 32'd4);
        repeat (3) cyc();
        checkOutput("wrap_addr", imem_addr, 32'h8);
        checkOutput("wrap_pc_atual", pc_atual, 32'h8);

        // Redirect to 0x100 while the request at 0x8 is still pending.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        cyc();
        checkOutput("pend_addr", imem_addr, 32'h8);
        checkOutput("pend_req", 32'(imem_req), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        cyc();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("disc_valid", 32'(instr_valid), 0);
        checkOutput("disc_addr", imem_addr, 32'h8);
        checkOutput("disc_req", 32'(imem_req), 1);
        checkOutput("disc_pc_atual", pc_atual, 32'h100);
        cyc();
        checkOutput("disc_addr_hold", imem_addr, 32'h8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        cyc();
        checkOutput("drop_valid", 32'(instr_valid), 0);
        checkOutput("drop_addr", imem_addr, 32'h100);

        // Consumer stalled: fetch stops once the buffer holds DEPTH entries.
        repeat (3) cyc();
        checkOutput("full_req", 32'(imem_req), 0);
        checkOutput("full_valid", 32'(instr_valid), 1);
        checkOutput("full_instr_pc", instr_pc, 32'h100);
        checkOutput("full_pc_atual", pc_atual, 32'h108);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (8) cyc();

        // Reset during a live request, then an ack while the unit is still idle.
        reset = 1'b0;
        #1;
        checkOutput("async_req", 32'(imem_req), 0);
        checkOutput("async_valid", 32'(instr_valid), 0);
        checkOutput("async_pc_atual", pc_atual, RST_PC);
        model_restart(RST_PC);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        checkOutput("late_ack_valid", 32'(instr_valid), 0);
        checkOutput("late_ack_addr", imem_addr, RST_PC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        cyc();
        checkOutput("late_ack_valid2", 32'(instr_valid), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        cyc();
        checkOutput("post_rst_valid", 32'(instr_valid), 1);
        checkOutput("post_rst_instr_pc", instr_pc, RST_PC);

        for (int c = 0; c < 3000; c++) begin
            logic a;
            logic r;
            logic d;
            if ($urandom_range(0, 999) < 3) begin
                reset = 1'b0;
                model_restart(RST_PC);
                applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
                repeat (2) cyc();
                reset = 1'b1;
            end
            a = ($urandom_range(0, 9) < 6);
            d = ($urandom_range(0, 19) == 0);
            r = d ? 1'b0 : ($urandom_range(0, 9) < 7);
            applyStimulus(a, r, d, $urandom);
            cyc();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        cyc();
        checkOutput("random_traffic", 32'(deliveries > 200), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
